// File: rtl/alu_pkg.sv
// Shared definitions for the shared-ALU arbiter slice:
// ALU op encodings, FSM state enum and data width.
package alu_pkg;

   localparam int DW = 16;

   localparam logic [1:0] OP_ADD  = 2'b00;
   localparam logic [1:0] OP_SUB  = 2'b01;
   localparam logic [1:0] OP_AND  = 2'b10;
   localparam logic [1:0] OP_NOTB = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_EXEC = 2'b01,
      S_RESP = 2'b10
   } state_t;

endpackage

// File: rtl/alu_share_arbiter_alu.sv
// ALU: combinational 16-bit add/sub/and/not-B.
// Ports: i_a, i_b operands, i_op op; o_y result, o_z/o_v/o_n flags (sub only).
module ALU
   import alu_pkg::*;
(
   input  logic [DW-1:0] i_a,
   input  logic [DW-1:0] i_b,
   input  logic [1:0]    i_op,
   output logic [DW-1:0] o_y,
   output logic          o_z,
   output logic          o_v,
   output logic          o_n
);

   logic [DW-1:0] w_diff;

   assign w_diff = i_a - i_b;

   always_comb begin
      o_y = '0;
      o_z = 1'b0;
      o_v = 1'b0;
      o_n = 1'b0;
      unique case (i_op)
         OP_ADD: o_y = i_a + i_b;
         OP_SUB: begin
            o_y = w_diff;
            o_z = (w_diff == '0);
            // signed overflow: operand signs differ and result sign flips from A
            o_v = (i_a[DW-1] != i_b[DW-1]) &&
                  (w_diff[DW-1] != i_a[DW-1]);
            o_n = w_diff[DW-1];
         end
         OP_AND:  o_y = i_a & i_b;
         OP_NOTB: o_y = ~i_b;
      endcase
   end

endmodule

// File: rtl/alu_share_arbiter.sv
// Two requesters share one ALU via round-robin grant; IDLE/EXEC/RESP FSM.
// Ports: req_* per-requester requests, rsp_* result handshake, done_cnt0/1 counts.
module alu_share_arbiter
   import alu_pkg::*;
(
   input  logic            clk,
   input  logic            rst_n,
   input  logic [1:0]      req_valid,
   input  logic [2*DW-1:0] req_ain,
   input  logic [2*DW-1:0] req_bin,
   input  logic [3:0]      req_aluop,
   output logic [1:0]      req_ready,
   output logic            rsp_valid,
   input  logic            rsp_ready,
   output logic            rsp_id,
   output logic [DW-1:0]   rsp_out,
   output logic            rsp_z,
   output logic            rsp_v,
   output logic            rsp_n,
   output logic [7:0]      done_cnt0,
   output logic [7:0]      done_cnt1
);

   state_t        r_state;
   logic          r_last;
   logic          r_id;
   logic [DW-1:0] r_a;
   logic [DW-1:0] r_b;
   logic [1:0]    r_op;
   logic          r_rv;
   logic          r_rid;
   logic [DW-1:0] r_out;
   logic          r_z;
   logic          r_v;
   logic          r_n;
   logic [7:0]    r_cnt0;
   logic [7:0]    r_cnt1;

   logic          w_gnt;
   logic          w_take;
   logic [DW-1:0] w_y;
   logic          w_z;
   logic          w_v;
   logic          w_n;

   // on a tie, favour the requester that was not served last
   always_comb begin
      w_gnt = 1'b0;
      unique case (req_valid)
         2'b11:   w_gnt = ~r_last;
         2'b10:   w_gnt = 1'b1;
         default: w_gnt = 1'b0;
      endcase
   end

   assign w_take    = rst_n && (r_state == S_IDLE) && (|req_valid);
   assign req_ready = {w_take & w_gnt, w_take & ~w_gnt};

   ALU u_alu (
      .i_a  (r_a),
      .i_b  (r_b),
      .i_op (r_op),
      .o_y  (w_y),
      .o_z  (w_z),
      .o_v  (w_v),
      .o_n  (w_n)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_last  <= 1'b1;
         r_id    <= 1'b0;
         r_a     <= '0;
         r_b     <= '0;
         r_op    <= '0;
         r_rv    <= 1'b0;
         r_rid   <= 1'b0;
         r_out   <= '0;
         r_z     <= 1'b0;
         r_v     <= 1'b0;
         r_n     <= 1'b0;
         r_cnt0  <= '0;
         r_cnt1  <= '0;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               if (w_take) begin
                  r_a     <= w_gnt ? req_ain[2*DW-1:DW] : req_ain[DW-1:0];
                  r_b     <= w_gnt ? req_bin[2*DW-1:DW] : req_bin[DW-1:0];
                  r_op    <= w_gnt ? req_aluop[3:2] : req_aluop[1:0];
                  r_id    <= w_gnt;
                  r_last  <= w_gnt;
                  r_state <= S_EXEC;
               end
            end
            S_EXEC: begin
               r_out   <= w_y;
               r_z     <= w_z;
               r_v     <= w_v;
               r_n     <= w_n;
               r_rid   <= r_id;
               r_rv    <= 1'b1;
               r_state <= S_RESP;
            end
            S_RESP: begin
               if (rsp_ready) begin
                  r_rv    <= 1'b0;
                  r_state <= S_IDLE;
                  if (r_rid) r_cnt1 <= r_cnt1 + 8'd1;
                  else       r_cnt0 <= r_cnt0 + 8'd1;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign rsp_valid = r_rv;
   assign rsp_id    = r_rid;
   assign rsp_out   = r_out;
   assign rsp_z     = r_z;
   assign rsp_v     = r_v;
   assign rsp_n     = r_n;
   assign done_cnt0 = r_cnt0;
   assign done_cnt1 = r_cnt1;

endmodule
